// File: rtl/mmu_pkg.sv
// Shared constants for the segmented address translation unit.
// Optional fault counter enabled by MMU_FAULT_COUNT_EN.
package mmu_pkg;

   localparam int VA_W_DEF    = 16;
   localparam int PA_W_DEF    = 32;
   localparam int NSEG_DEF    = 4;
   localparam int FAULT_CNT_W = 8;

   localparam logic CFG_FIELD_BASE  = 1'b0;
   localparam logic CFG_FIELD_LIMIT = 1'b1;

endpackage

// File: rtl/mmu_seg_regfile.sv
// Base/limit segment register file: one write port, one
// combinational read port. Reset state is the identity map.
module mmu_seg_regfile
   import mmu_pkg::*;
#(
   parameter  int VA_W  = VA_W_DEF,
   parameter  int PA_W  = PA_W_DEF,
   parameter  int NSEG  = NSEG_DEF,
   localparam int SEG_W = $clog2(NSEG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [SEG_W-1:0] wsel,
   input  logic             wfield,
   input  logic [PA_W-1:0]  wdata,
   input  logic [SEG_W-1:0] rsel,
   output logic [PA_W-1:0]  rbase,
   output logic [VA_W-1:0]  rlimit
);

   logic [PA_W-1:0] base_q  [NSEG];
   logic [VA_W-1:0] limit_q [NSEG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSEG; i++) begin
            base_q[i]  <= '0;
            limit_q[i] <= '1;
         end
      end else if (we) begin
         if (wfield == CFG_FIELD_LIMIT)
            limit_q[wsel] <= wdata[VA_W-1:0];
         else
            base_q[wsel] <= wdata;
      end
   end

   assign rbase  = base_q[rsel];
   assign rlimit = limit_q[rsel];

endmodule

// File: rtl/mmu_seg_xlate.sv
// Segmented VA->PA translator with one registered response stage.
// Define MMU_FAULT_COUNT_EN to add the saturating fault_cnt output.
module mmu_seg_xlate
   import mmu_pkg::*;
#(
   parameter  int VA_W  = VA_W_DEF,
   parameter  int PA_W  = PA_W_DEF,
   parameter  int NSEG  = NSEG_DEF,
   localparam int SEG_W = $clog2(NSEG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [VA_W-1:0]  req_va,
   input  logic [SEG_W-1:0] req_seg,
   input  logic             cfg_we,
   input  logic [SEG_W-1:0] cfg_sel,
   input  logic             cfg_field,
   input  logic [PA_W-1:0]  cfg_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [PA_W-1:0]  rsp_pa,
   output logic             rsp_fault,
   output logic             fault_sticky,
   output logic [VA_W-1:0]  fault_va,
`ifdef MMU_FAULT_COUNT_EN
   output logic [FAULT_CNT_W-1:0] fault_cnt,
`endif
   input  logic             fault_clr
);

   logic [PA_W-1:0] seg_base;
   logic [VA_W-1:0] seg_limit;
   logic [PA_W-1:0] va_z;
   logic [PA_W-1:0] xlate_pa;
   logic            accept;
   logic            va_fault;

   mmu_seg_regfile #(
      .VA_W (VA_W),
      .PA_W (PA_W),
      .NSEG (NSEG)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (cfg_we),
      .wsel   (cfg_sel),
      .wfield (cfg_field),
      .wdata  (cfg_data),
      .rsel   (req_seg),
      .rbase  (seg_base),
      .rlimit (seg_limit)
   );

   assign req_ready = !reset && (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign va_z      = PA_W'(req_va);
   assign va_fault  = en && (req_va > seg_limit);

   // Base addition wraps silently modulo 2^PA_W.
   always_comb begin
      xlate_pa = va_z;
      unique case (1'b1)
         !en:      xlate_pa = va_z;
         va_fault: xlate_pa = '0;
         default:  xlate_pa = seg_base + va_z;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_pa    <= '0;
         rsp_fault <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_pa    <= xlate_pa;
         rsp_fault <= va_fault;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // A fault coinciding with a clear restarts the capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_sticky <= 1'b0;
         fault_va     <= '0;
      end else if (accept && va_fault) begin
         fault_sticky <= 1'b1;
         if (!fault_sticky || fault_clr)
            fault_va <= req_va;
      end else if (fault_clr) begin
         fault_sticky <= 1'b0;
         fault_va     <= '0;
      end
   end

`ifdef MMU_FAULT_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_cnt <= '0;
      end else if (accept && va_fault) begin
         if (fault_clr)
            fault_cnt <= FAULT_CNT_W'(1);
         else if (fault_cnt != '1)
            fault_cnt <= fault_cnt + 1'b1;
      end else if (fault_clr) begin
         fault_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_mmu_seg_xlate.sv
// Self-checking bench for mmu_seg_xlate: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_mmu_seg_xlate;

   localparam int VA_W = 16;
   localparam int PA_W = 32;
   localparam int NSEG = 4;
   localparam int SEG_W = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [VA_W-1:0]  req_va = '0;
   logic [SEG_W-1:0] req_seg = '0;
   logic             cfg_we = 1'b0;
   logic [SEG_W-1:0] cfg_sel = '0;
   logic             cfg_field = 1'b0;
   logic [PA_W-1:0]  cfg_data = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [PA_W-1:0]  rsp_pa;
   logic             rsp_fault;
   logic             fault_sticky;
   logic [VA_W-1:0]  fault_va;
   logic             fault_clr = 1'b0;
`ifdef MMU_FAULT_COUNT_EN
   logic [7:0]       fault_cnt;
`endif

   int total = 0;
   int bad = 0;

   // reference model state
   logic            m_valid;
   logic [PA_W-1:0] m_pa;
   logic            m_fault;
   logic            m_sticky;
   logic [VA_W-1:0] m_fva;
   int              m_cnt;
   logic [PA_W-1:0] m_base [NSEG];
   logic [VA_W-1:0] m_limit [NSEG];

   always #5 clk = ~clk;

   mmu_seg_xlate dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_va       (req_va),
      .req_seg      (req_seg),
      .cfg_we       (cfg_we),
      .cfg_sel      (cfg_sel),
      .cfg_field    (cfg_field),
      .cfg_data     (cfg_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_pa       (rsp_pa),
      .rsp_fault    (rsp_fault),
      .fault_sticky (fault_sticky),
      .fault_va     (fault_va),
`ifdef MMU_FAULT_COUNT_EN
      .fault_cnt    (fault_cnt),
`endif
      .fault_clr    (fault_clr)
   );

   // Advance one clock; the model applies the rules to the
   // inputs present at the edge, then outputs are sampled at +1.
   task automatic tick();
      logic            acc;
      logic            f;
      logic [PA_W-1:0] p;
      acc = !reset && req_valid && (!m_valid || rsp_ready);
      f = en && (req_va > m_limit[req_seg]);
      if (!en) p = PA_W'(req_va);
      else if (f) p = '0;
      else p = m_base[req_seg] + PA_W'(req_va);
      if (reset) begin
         m_valid = 0; m_pa = '0; m_fault = 0;
         m_sticky = 0; m_fva = '0; m_cnt = 0;
         for (int i = 0; i < NSEG; i++) begin
            m_base[i] = '0;
            m_limit[i] = '1;
         end
      end else begin
         if (acc) begin
            m_valid = 1; m_pa = p; m_fault = f;
         end else if (rsp_ready) begin
            m_valid = 0;
         end
         if (acc && f) begin
            if (!m_sticky || fault_clr) m_fva = req_va;
            m_sticky = 1;
            if (fault_clr) m_cnt = 1;
            else if (m_cnt < 255) m_cnt = m_cnt + 1;
         end else if (fault_clr) begin
            m_sticky = 0; m_fva = '0; m_cnt = 0;
         end
         if (cfg_we) begin
            if (cfg_field) m_limit[cfg_sel] = cfg_data[VA_W-1:0];
            else m_base[cfg_sel] = cfg_data;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int sel, input logic fld,
                      input logic [PA_W-1:0] d);
      cfg_we = 1; cfg_sel = SEG_W'(sel);
      cfg_field = fld; cfg_data = d;
      tick();
      cfg_we = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      tick();
      tick();
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_ready got=%b want=0", req_ready);
      end
      reset = 0;
      #1;
      total++;
      if (rsp_valid !== 0 || rsp_pa !== 0 || rsp_fault !== 0 ||
          fault_sticky !== 0 || fault_va !== 0) begin
         bad++;
         $display("FAIL rst_state got v=%b pa=%h f=%b s=%b fva=%h want 0",
                  rsp_valid, rsp_pa, rsp_fault, fault_sticky, fault_va);
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_ready_after got=%b want=1", req_ready);
      end
`ifdef MMU_FAULT_COUNT_EN
      total++;
      if (fault_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rst_cnt got=%0d want=0", fault_cnt);
      end
`endif
   endtask

   task automatic test_identity();
      en = 1; req_valid = 1; req_va = 16'h1234; req_seg = 0;
      tick();
      req_valid = 0;
      total++;
      if (rsp_valid !== 1 || rsp_pa !== 32'h0000_1234 ||
          rsp_fault !== 0) begin
         bad++;
         $display("FAIL identity got v=%b pa=%h f=%b want 1/00001234/0",
                  rsp_valid, rsp_pa, rsp_fault);
      end
      tick();
      total++;
      if (rsp_valid !== 0) begin
         bad++;
         $display("FAIL identity_retire got=%b want=0", rsp_valid);
      end
   endtask

   task automatic test_seg_config();
      cfg(2, 1'b1, 32'h0000_0FFF);
      cfg(2, 1'b0, 32'h8000_0000);
      en = 1; req_valid = 1; req_seg = 2; req_va = 16'h0FFF;
      tick();
      total++;
      if (rsp_pa !== 32'h8000_0FFF || rsp_fault !== 0) begin
         bad++;
         $display("FAIL seg_limit_edge got pa=%h f=%b want 80000fff/0",
                  rsp_pa, rsp_fault);
      end
      req_va = 16'h1000;
      tick();
      req_valid = 0;
      total++;
      if (rsp_pa !== 0 || rsp_fault !== 1 || fault_sticky !== 1 ||
          fault_va !== 16'h1000) begin
         bad++;
         $display("FAIL seg_limit_p1 got pa=%h f=%b s=%b fva=%h",
                  rsp_pa, rsp_fault, fault_sticky, fault_va);
      end
      fault_clr = 1;
      tick();
      fault_clr = 0;
      total++;
      if (fault_sticky !== 0 || fault_va !== 0) begin
         bad++;
         $display("FAIL clr got s=%b fva=%h want 0/0",
                  fault_sticky, fault_va);
      end
   endtask

   task automatic test_wrap_and_legacy();
      cfg(3, 1'b0, 32'hFFFF_FFF0);
      en = 1; req_valid = 1; req_seg = 3; req_va = 16'h0020;
      tick();
      total++;
      if (rsp_pa !== 32'h0000_0010 || rsp_fault !== 0) begin
         bad++;
         $display("FAIL wrap got pa=%h f=%b want 00000010/0",
                  rsp_pa, rsp_fault);
      end
      en = 0; req_seg = 2; req_va = 16'hABCD;
      tick();
      req_valid = 0; en = 1;
      total++;
      if (rsp_pa !== 32'h0000_ABCD || rsp_fault !== 0 ||
          fault_sticky !== 0) begin
         bad++;
         $display("FAIL legacy got pa=%h f=%b s=%b want 0000abcd/0/0",
                  rsp_pa, rsp_fault, fault_sticky);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      en = 1; req_seg = 0; rsp_ready = 0;
      req_valid = 1; req_va = 16'h0100;
      tick();
      req_va = 16'h0101;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (req_ready !== 0 || rsp_valid !== 1 ||
             rsp_pa !== 32'h0000_0100) begin
            bad++;
            $display("FAIL stall%0d got rdy=%b v=%b pa=%h", i,
                     req_ready, rsp_valid, rsp_pa);
         end
      end
      rsp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         req_va = VA_W'(16'h0101 + i);
         tick();
         total++;
         if (rsp_valid !== 1 || rsp_pa !== PA_W'(32'h0101 + i)) begin
            bad++;
            $display("FAIL stream%0d got v=%b pa=%h want %h", i,
                     rsp_valid, rsp_pa, 32'h0101 + i);
         end
      end
      req_valid = 0;
      tick();
      total++;
      if (rsp_valid !== 0) begin
         bad++;
         $display("FAIL stream_drain got=%b want=0", rsp_valid);
      end
   endtask

   task automatic test_fault_capture();
      en = 1; req_valid = 1; req_seg = 2; req_va = 16'h2000;
      tick();
      req_va = 16'h3000;
      tick();
      total++;
      if (fault_sticky !== 1 || fault_va !== 16'h2000) begin
         bad++;
         $display("FAIL first_fault got s=%b fva=%h want 1/2000",
                  fault_sticky, fault_va);
      end
`ifdef MMU_FAULT_COUNT_EN
      total++;
      if (fault_cnt !== 8'd2) begin
         bad++;
         $display("FAIL cnt2 got=%0d want=2", fault_cnt);
      end
`endif
      fault_clr = 1; req_va = 16'h4000;
      tick();
      fault_clr = 0; req_valid = 0;
      total++;
      if (fault_sticky !== 1 || fault_va !== 16'h4000) begin
         bad++;
         $display("FAIL clr_vs_fault got s=%b fva=%h want 1/4000",
                  fault_sticky, fault_va);
      end
`ifdef MMU_FAULT_COUNT_EN
      total++;
      if (fault_cnt !== 8'd1) begin
         bad++;
         $display("FAIL cnt_clr_fault got=%0d want=1", fault_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_cfg_collision();
      en = 1; req_valid = 1; req_seg = 1; req_va = 16'h0010;
      cfg(1, 1'b0, 32'h0001_0000);
      total++;
      if (rsp_pa !== 32'h0000_0010) begin
         bad++;
         $display("FAIL cfg_same_edge got=%h want=00000010", rsp_pa);
      end
      tick();
      req_valid = 0;
      total++;
      if (rsp_pa !== 32'h0001_0010) begin
         bad++;
         $display("FAIL cfg_next got=%h want=00010010", rsp_pa);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      en = 1; req_valid = 1; req_seg = 2; req_va = 16'h2000;
      tick();
      rsp_ready = 0; req_seg = 1; req_va = 16'h0055;
      tick();
      req_valid = 0; reset = 1;
      tick();
      reset = 0; rsp_ready = 1;
      total++;
      if (rsp_valid !== 0 || rsp_pa !== 0 || rsp_fault !== 0 ||
          fault_sticky !== 0 || fault_va !== 0) begin
         bad++;
         $display("FAIL mid_reset got v=%b pa=%h f=%b s=%b fva=%h",
                  rsp_valid, rsp_pa, rsp_fault, fault_sticky, fault_va);
      end
      req_valid = 1; req_seg = 1; req_va = 16'h0010;
      tick();
      total++;
      if (rsp_pa !== 32'h0000_0010) begin
         bad++;
         $display("FAIL mid_reset_base got=%h want=00000010", rsp_pa);
      end
      req_seg = 2; req_va = 16'hF000;
      tick();
      req_valid = 0;
      total++;
      if (rsp_pa !== 32'h0000_F000 || rsp_fault !== 0) begin
         bad++;
         $display("FAIL mid_reset_limit got pa=%h f=%b", rsp_pa,
                  rsp_fault);
      end
      tick();
   endtask

   task automatic test_random();
      logic [VA_W-1:0] lim;
      for (int n = 0; n < 400; n++) begin
         en = ($urandom_range(0, 9) != 0);
         req_valid = $urandom_range(0, 3) != 0;
         rsp_ready = $urandom_range(0, 3) != 0;
         req_seg = SEG_W'($urandom_range(0, NSEG - 1));
         lim = m_limit[req_seg];
         case ($urandom_range(0, 3))
            0: req_va = lim;
            1: req_va = lim + 1'b1;
            default: req_va = VA_W'($urandom);
         endcase
         fault_clr = $urandom_range(0, 19) == 0;
         cfg_we = $urandom_range(0, 9) == 0;
         cfg_sel = SEG_W'($urandom_range(0, NSEG - 1));
         cfg_field = $urandom_range(0, 1) != 0;
         cfg_data = $urandom;
         #1;
         total++;
         if (req_ready !== (!m_valid || rsp_ready)) begin
            bad++;
            $display("FAIL rnd_ready n=%0d got=%b want=%b", n,
                     req_ready, !m_valid || rsp_ready);
         end
         tick();
         total++;
         if (rsp_valid !== m_valid ||
             (m_valid && (rsp_pa !== m_pa || rsp_fault !== m_fault)) ||
             fault_sticky !== m_sticky || fault_va !== m_fva) begin
            bad++;
            $display("FAIL rnd n=%0d got v=%b pa=%h f=%b s=%b fva=%h want v=%b pa=%h f=%b s=%b fva=%h",
                     n, rsp_valid, rsp_pa, rsp_fault, fault_sticky,
                     fault_va, m_valid, m_pa, m_fault, m_sticky, m_fva);
         end
`ifdef MMU_FAULT_COUNT_EN
         total++;
         if (fault_cnt !== 8'(m_cnt)) begin
            bad++;
            $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n,
                     fault_cnt, m_cnt);
         end
`endif
      end
      cfg_we = 0; fault_clr = 0; req_valid = 0; rsp_ready = 1;
      tick();
   endtask

   initial begin
      m_valid = 0; m_pa = '0; m_fault = 0;
      m_sticky = 0; m_fva = '0; m_cnt = 0;
      for (int i = 0; i < NSEG; i++) begin
         m_base[i] = '0;
         m_limit[i] = '1;
      end
      @(negedge clk);
      test_reset();
      test_identity();
      test_seg_config();
      test_wrap_and_legacy();
      test_back_to_back();
      test_fault_capture();
      test_cfg_collision();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
